buyruk_ffram_denetleyici: RTL and testbench

Direct-mapped instruction-cache controller that sequences the 512x41 byte-enabled instruction FFRAM (async read, sync write). It serves fetch lookups from the core, refills misses from lower memory over a request/response handshake, and walks the array to invalidate all entries after reset and on fence.i. Sits between the fetch stage, the FFRAM instance and the memory arbiter.

---
 rtl/buyruk_ffram_denetleyici_pkg.sv | 64 ++++++
 rtl/buyruk_ffram_denetleyici.sv | 211 +++++++++++++++++++++
 tb/tb_buyruk_ffram_denetleyici.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/buyruk_ffram_denetleyici_pkg.sv
// Shared definitions for the instruction-cache controller that drives the
// 512x41 instruction FFRAM: FSM state encoding, entry field positions,
// fetch-address slices and small helpers for building and splitting entries.
package buyruk_ffram_denetleyici_pkg;

    // Geometry of the array and of one entry {valid, tag, instr}.
    localparam int SATIR_N   = 512;
    localparam int ETIKET_W  = 8;
    localparam int SIRA_W    = $clog2(SATIR_N);
    localparam int VERI_W    = 32;
    localparam int GIRIS_W   = 1 + ETIKET_W + VERI_W;

    // Field positions inside a stored entry.
    localparam int VALID_BIT  = 40;
    localparam int ETIKET_MSB = 39;
    localparam int ETIKET_LSB = 32;
    localparam int VERI_MSB   = 31;

    // Where index and tag live in a fetch byte address.
    localparam int SIRA_LSB       = 2;
    localparam int SIRA_MSB       = SIRA_LSB + SIRA_W - 1;
    localparam int ADR_ETIKET_LSB = SIRA_MSB + 1;
    localparam int ADR_ETIKET_MSB = ADR_ETIKET_LSB + ETIKET_W - 1;

    // Byte-lane write enables: lane 4 holds {valid, tag}, lanes 3..0 the word.
    localparam logic [4:0] WEN_YOK     = 5'b00000;
    localparam logic [4:0] WEN_TEMIZLE = 5'b10000;
    localparam logic [4:0] WEN_YAZ     = 5'b11111;

    // Last row the invalidation walk touches before going idle.
    localparam logic [SIRA_W-1:0] SON_SATIR = SIRA_W'(SATIR_N - 1);

    // Controller states.
    typedef enum logic [2:0] {
        TEMIZLE = 3'd0,  // walking the array, clearing valid bits
        BOSTA   = 3'd1,  // idle, serving hits
        ISTE    = 3'd2,  // requesting a line from lower memory
        BEKLE   = 3'd3,  // waiting for lower-memory data
        YAZ     = 3'd4   // writing the refilled entry and responding
    } durum_t;

    // Row index selected by a fetch byte address.
    function automatic logic [SIRA_W-1:0] adres_sira(input logic [31:0] adres);
        return adres[SIRA_MSB:SIRA_LSB];
    endfunction

    // Tag carried by a fetch byte address.
    function automatic logic [ETIKET_W-1:0] adres_etiket(input logic [31:0] adres);
        return adres[ADR_ETIKET_MSB:ADR_ETIKET_LSB];
    endfunction

    // A valid entry holding the given tag and instruction word.
    function automatic logic [GIRIS_W-1:0] giris_yap(input logic [ETIKET_W-1:0] etiket,
                                                     input logic [VERI_W-1:0]   veri);
        return {1'b1, etiket, veri};
    endfunction

    // True when a stored entry is valid and its tag matches.
    function automatic logic giris_eslesir(input logic [GIRIS_W-1:0]  giris,
                                           input logic [ETIKET_W-1:0] etiket);
        return giris[VALID_BIT] && (giris[ETIKET_MSB:ETIKET_LSB] == etiket);
    endfunction

endpackage

// File: rtl/buyruk_ffram_denetleyici.sv
// Direct-mapped instruction-cache controller in front of the 512x41
// byte-enabled instruction FFRAM (asynchronous read, synchronous write).
// Hits are answered in the same cycle from the FFRAM read port; misses are
// refilled from lower memory over a request/response handshake; the whole
// array is invalidated after reset and on fence.i.
//
// Handshakes:
//   fetch  : ist_gecerli_i is held with a stable ist_adres_i until the
//            single-cycle yan_gecerli_o pulse that answers it.
//   memory : the request transfers on a cycle where bel_istek_o and
//            bel_hazir_i are both high; bel_istek_o then drops and the data
//            is taken on the first later cycle with bel_gecerli_i high.
//            bel_gecerli_i outside that waiting window is ignored.
//
// Optional build macro: BUYRUK_DENETLEYICI_SAYAC_EN adds 32-bit hit and miss
// counters (isabet_sayisi_o, iska_sayisi_o), cleared only by reset.
module buyruk_ffram_denetleyici
    import buyruk_ffram_denetleyici_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,

    // Fetch side
    input  logic                ist_gecerli_i,
    input  logic [31:0]         ist_adres_i,
    output logic                yan_gecerli_o,
    output logic [31:0]         yan_veri_o,
    output logic                mesgul_o,
    input  logic                temizle_i,

`ifdef BUYRUK_DENETLEYICI_SAYAC_EN
    // Statistics
    output logic [31:0]         isabet_sayisi_o,
    output logic [31:0]         iska_sayisi_o,
`endif

    // Lower-memory side
    output logic                bel_istek_o,
    output logic [31:0]         bel_adres_o,
    input  logic                bel_hazir_i,
    input  logic                bel_gecerli_i,
    input  logic [31:0]         bel_veri_i,

    // FFRAM side
    output logic [4:0]          ram_wen_o,
    output logic [GIRIS_W-1:0]  ram_veri_o,
    output logic [SIRA_W-1:0]   ram_yadr_o,
    output logic [SIRA_W-1:0]   ram_oadr_o,
    input  logic [GIRIS_W-1:0]  ram_veri_i
);

    durum_t              durum;
    logic [SIRA_W-1:0]   sayac;            // invalidation walk row
    logic                bekleyen_temizle; // fence.i seen during a refill
    logic [31:2]         adres_q;          // word address of the missing fetch
    logic [VERI_W-1:0]   veri_q;           // word returned by lower memory
    logic                yaz_gecerli_q;    // response pulse of the refill
    logic                bel_istek_q;
    logic                mesgul_q;

    logic [31:0]         adres_tam;
    logic                isabet;
    logic                bosta_isabet;
    logic                bosta_iska;
    logic                adres_unused;

    // The low two address bits never matter: fetches are word aligned.
    assign adres_unused = ^ist_adres_i[1:0];

    assign adres_tam  = {adres_q, 2'b00};
    assign ram_oadr_o = adres_sira(ist_adres_i);
    assign isabet     = giris_eslesir(ram_veri_i, adres_etiket(ist_adres_i));

    // A fence.i in the same idle cycle wins over the fetch, which then waits.
    assign bosta_isabet = (durum == BOSTA) && !temizle_i && ist_gecerli_i && isabet;
    assign bosta_iska   = (durum == BOSTA) && !temizle_i && ist_gecerli_i && !isabet;

    // Control FSM with its registered handshake and status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum            <= TEMIZLE;
            sayac            <= '0;
            bekleyen_temizle <= 1'b0;
            adres_q          <= '0;
            veri_q           <= '0;
            yaz_gecerli_q    <= 1'b0;
            bel_istek_q      <= 1'b0;
            mesgul_q         <= 1'b1;
        end else begin
            yaz_gecerli_q <= 1'b0;
            case (durum)
                TEMIZLE: begin
                    if (temizle_i) begin
                        sayac <= '0;
                    end else if (sayac == SON_SATIR) begin
                        sayac    <= '0;
                        durum    <= BOSTA;
                        mesgul_q <= 1'b0;
                    end else begin
                        sayac <= sayac + SIRA_W'(1);
                    end
                end
                BOSTA: begin
                    if (temizle_i) begin
                        sayac    <= '0;
                        durum    <= TEMIZLE;
                        mesgul_q <= 1'b1;
                    end else if (bosta_iska) begin
                        adres_q     <= ist_adres_i[31:2];
                        durum       <= ISTE;
                        bel_istek_q <= 1'b1;
                        mesgul_q    <= 1'b1;
                    end
                end
                ISTE: begin
                    if (temizle_i) begin
                        bekleyen_temizle <= 1'b1;
                    end
                    if (bel_hazir_i) begin
                        bel_istek_q <= 1'b0;
                        durum       <= BEKLE;
                    end
                end
                BEKLE: begin
                    if (temizle_i) begin
                        bekleyen_temizle <= 1'b1;
                    end
                    if (bel_gecerli_i) begin
                        veri_q        <= bel_veri_i;
                        yaz_gecerli_q <= 1'b1;
                        durum         <= YAZ;
                    end
                end
                YAZ: begin
                    // The refill has answered; a deferred fence.i runs now.
                    if (bekleyen_temizle || temizle_i) begin
                        bekleyen_temizle <= 1'b0;
                        sayac            <= '0;
                        durum            <= TEMIZLE;
                    end else begin
                        durum    <= BOSTA;
                        mesgul_q <= 1'b0;
                    end
                end
                default: begin
                    sayac            <= '0;
                    bekleyen_temizle <= 1'b0;
                    bel_istek_q      <= 1'b0;
                    mesgul_q         <= 1'b1;
                    durum            <= TEMIZLE;
                end
            endcase
        end
    end

    // FFRAM write port: clearing walk or refill write, nothing otherwise.
    always_comb begin
        ram_wen_o  = WEN_YOK;
        ram_veri_o = '0;
        ram_yadr_o = '0;
        if (!rst_i) begin
            case (durum)
                TEMIZLE: begin
                    ram_wen_o  = WEN_TEMIZLE;
                    ram_yadr_o = sayac;
                end
                YAZ: begin
                    ram_wen_o  = WEN_YAZ;
                    ram_veri_o = giris_yap(adres_etiket(adres_tam), veri_q);
                    ram_yadr_o = adres_sira(adres_tam);
                end
                default: begin
                    ram_wen_o = WEN_YOK;
                end
            endcase
        end
    end

    // Fetch response: same-cycle hit or the registered refill word.
    always_comb begin
        yan_gecerli_o = yaz_gecerli_q || bosta_isabet;
        yan_veri_o    = '0;
        if (yaz_gecerli_q) begin
            yan_veri_o = veri_q;
        end else if (bosta_isabet) begin
            yan_veri_o = ram_veri_i[VERI_MSB:0];
        end
    end

    assign bel_istek_o = bel_istek_q;
    assign bel_adres_o = adres_tam;
    assign mesgul_o    = mesgul_q;

`ifdef BUYRUK_DENETLEYICI_SAYAC_EN
    // Hit/miss statistics; wrap naturally at 2^32.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            isabet_sayisi_o <= '0;
            iska_sayisi_o   <= '0;
        end else begin
            if (bosta_isabet) begin
                isabet_sayisi_o <= isabet_sayisi_o + 32'd1;
            end
            if (bosta_iska) begin
                iska_sayisi_o <= iska_sayisi_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_buyruk_ffram_denetleyici.sv
// Bench for the instruction-cache controller: models the FFRAM and a lower
// memory, predicts every fetch response from a small cache model, and checks
// responses and memory requests through scoreboard queues.
module tb_buyruk_ffram_denetleyici;

    localparam int SATIR = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        ist_gecerli;
    logic [31:0] ist_adres;
    logic        yan_gecerli;
    logic [31:0] yan_veri;
    logic        mesgul;
    logic        temizle;
    logic        bel_istek;
    logic [31:0] bel_adres;
    logic        bel_hazir;
    logic        bel_gecerli;
    logic [31:0] bel_veri;
    logic [4:0]  ram_wen;
    logic [40:0] ram_yveri;
    logic [8:0]  ram_yadr;
    logic [8:0]  ram_oadr;
    logic [40:0] ram_overi;
`ifdef BUYRUK_DENETLEYICI_SAYAC_EN
    logic [31:0] isabet_sayisi;
    logic [31:0] iska_sayisi;
`endif

    buyruk_ffram_denetleyici dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .ist_gecerli_i (ist_gecerli),
        .ist_adres_i   (ist_adres),
        .yan_gecerli_o (yan_gecerli),
        .yan_veri_o    (yan_veri),
        .mesgul_o      (mesgul),
        .temizle_i     (temizle),
`ifdef BUYRUK_DENETLEYICI_SAYAC_EN
        .isabet_sayisi_o (isabet_sayisi),
        .iska_sayisi_o   (iska_sayisi),
`endif
        .bel_istek_o   (bel_istek),
        .bel_adres_o   (bel_adres),
        .bel_hazir_i   (bel_hazir),
        .bel_gecerli_i (bel_gecerli),
        .bel_veri_i    (bel_veri),
        .ram_wen_o     (ram_wen),
        .ram_veri_o    (ram_yveri),
        .ram_yadr_o    (ram_yadr),
        .ram_oadr_o    (ram_oadr),
        .ram_veri_i    (ram_overi)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- FFRAM model: async read, byte-lane sync write ----------------
    logic [40:0] ffram [0:SATIR-1];
    assign ram_overi = ffram[ram_oadr];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_wen[b]) ffram[ram_yadr][8*b +: 8] <= ram_yveri[8*b +: 8];
        if (ram_wen[4]) ffram[ram_yadr][40:32] <= ram_yveri[40:32];
    end

    // ---------------- bookkeeping ----------------
    int hata_sayisi = 0;
    int kontrol_sayisi = 0;
    logic [31:0] exp_q[$];      // expected fetch responses
    logic [31:0] exp_bel_q[$];  // expected lower-memory request addresses

    task automatic check(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
        kontrol_sayisi++;
        if (gercek !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: actual=%0h expected=%0h", ad, gercek, beklenen);
        end
    endtask

    task automatic hata_bildir(input string ad, input logic [63:0] gercek);
        kontrol_sayisi++;
        hata_sayisi++;
        $display("FAIL %s: actual=%0h expected=none", ad, gercek);
    endtask

    // ---------------- reference cache model ----------------
    bit          m_gecerli [SATIR];
    logic [7:0]  m_etiket  [SATIR];
    logic [31:0] m_veri    [SATIR];
    int          m_isabet = 0;
    int          m_iska   = 0;

    function automatic logic [31:0] alt_bellek(input logic [31:0] a);
        if (a == 32'h0000_1004) return 32'h00A0_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic void model_sil();
        foreach (m_gecerli[i]) m_gecerli[i] = 1'b0;
    endfunction

    // ---------------- lower-memory model ----------------
    bit          rastgele = 1'b0;
    int          gecikme = 2;
    bit          bekleyen = 1'b0;
    int          kalan = 0;
    logic [31:0] bekleyen_adr = '0;
    int          kabul_sayisi = 0;

    initial begin : alt_bellek_surucu
        bel_hazir = 1'b0;
        bel_gecerli = 1'b0;
        bel_veri = '0;
        forever begin
            @(posedge clk); #1;
            bel_gecerli = 1'b0;
            if (bekleyen) begin
                if (kalan == 0) begin
                    bel_gecerli = 1'b1;
                    bel_veri = alt_bellek(bekleyen_adr);
                    bekleyen = 1'b0;
                end else begin
                    kalan--;
                end
            end else if (rastgele && $urandom_range(0, 7) == 0) begin
                bel_gecerli = 1'b1;  // stray beat, must be ignored
                bel_veri = 32'hDEAD_BEEF;
            end
            bel_hazir = rastgele ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Request monitor: each accepted request must be one the model predicted.
    initial begin : alt_bellek_kabul
        forever begin
            @(negedge clk);
            if (!rst && bel_istek && bel_hazir) begin
                kabul_sayisi++;
                if (exp_bel_q.size() == 0) hata_bildir("bel_istek_beklenmedik", bel_adres);
                else check("bel_adres", bel_adres, exp_bel_q.pop_front());
                bekleyen = 1'b1;
                bekleyen_adr = bel_adres;
                kalan = rastgele ? $urandom_range(0, 4) : gecikme;
            end
        end
    end

    // Response monitor: every pulse pops one expected word.
    initial begin : yanit_izleyici
        forever begin
            @(negedge clk);
            if (!rst && yan_gecerli) begin
                if (exp_q.size() == 0) hata_bildir("yan_beklenmedik", yan_veri);
                else check("yan_veri", yan_veri, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One fetch: predict, drive, wait for the response, check its latency.
    task automatic fetch(input logic [31:0] a);
        logic [8:0]  idx;
        logic [7:0]  tg;
        logic [31:0] d;
        bit          hit;
        bit          got;
        int          lat;
        idx = a[10:2];
        tg  = a[18:11];
        hit = m_gecerli[idx] && (m_etiket[idx] == tg);
        if (hit) begin
            exp_q.push_back(m_veri[idx]);
            m_isabet++;
        end else begin
            d = alt_bellek({a[31:2], 2'b00});
            exp_q.push_back(d);
            exp_bel_q.push_back({a[31:2], 2'b00});
            m_gecerli[idx] = 1'b1;
            m_etiket[idx]  = tg;
            m_veri[idx]    = d;
            m_iska++;
        end
        @(posedge clk); #1;
        ist_gecerli = 1'b1;
        ist_adres = a;
        lat = 0;
        got = 1'b0;
        while (lat < 300) begin
            @(negedge clk);
            if (yan_gecerli) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        @(posedge clk); #1;
        ist_gecerli = 1'b0;
        if (!got) hata_bildir("yanit_zaman_asimi", a);
        else if (hit) check("isabet_gecikme", lat, 0);
        else check("iska_gecikme_en_az_3", lat >= 3, 1);
    endtask

    // Follows one invalidation walk from its first cycle; optionally restarts
    // it with temizle after 'yeniden' cycles.
    task automatic bekle_temizlik(input int yeniden);
        int n;
        int beklenen;
        int yurume_hata;
        int toplam;
        toplam = (yeniden >= 0) ? yeniden + 1 + SATIR : SATIR;
        n = 0;
        yurume_hata = 0;
        while (n < 2000) begin
            temizle = (n == yeniden);
            @(negedge clk);
            if (!mesgul) break;
            beklenen = (yeniden >= 0 && n > yeniden) ? n - yeniden - 1 : n;
            if (ram_wen !== 5'b10000 || ram_yadr !== beklenen[8:0] || ram_yveri !== 41'd0)
                yurume_hata++;
            n++;
            @(posedge clk); #1;
        end
        temizle = 1'b0;
        check("temizle_sure", n, toplam);
        check("temizle_yurume", yurume_hata, 0);
        model_sil();
    endtask

    task automatic temizle_darbe();
        @(posedge clk); #1;
        temizle = 1'b1;
        @(posedge clk); #1;
        bekle_temizlik(-1);
    endtask

    // Synchronous reset with a check of the reset-time outputs.
    task automatic reset_uygula();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_mesgul", mesgul, 1);
        check("reset_yan_gecerli", yan_gecerli, 0);
        check("reset_yan_veri", yan_veri, 0);
        check("reset_bel_istek", bel_istek, 0);
        check("reset_bel_adres", bel_adres, 0);
        check("reset_ram_wen", ram_wen, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ist_gecerli = 1'b0;
        model_sil();
        m_isabet = 0;
        m_iska = 0;
    endtask

    task automatic kabul_bekle(input int k0);
        for (int i = 0; i < 100 && kabul_sayisi == k0; i++) @(negedge clk);
        check("kabul_bekle", kabul_sayisi != k0, 1);
    endtask

    task automatic sayac_kontrol();
`ifdef BUYRUK_DENETLEYICI_SAYAC_EN
        check("isabet_sayisi", isabet_sayisi, m_isabet);
        check("iska_sayisi", iska_sayisi, m_iska);
`endif
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] rast_adr;
    int          k0;

    initial begin
        rst = 1'b1;
        ist_gecerli = 1'b0;
        ist_adres = '0;
        temizle = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_uygula();
        bekle_temizlik(-1);

        // First miss refills index 1 with tag 2.
        gecikme = 2;
        fetch(32'h0000_1004);
        check("ffram_satir1", ffram[1], 41'h1_02_00A0_0093);
        // Same address hits with no memory request.
        fetch(32'h0000_1004);
        // Same index, other tag: conflict miss, then the original misses again.
        fetch(32'h0000_1804);
        check("ffram_satir1_ust", ffram[1][40:32], 9'h103);
        fetch(32'h0000_1004);
        sayac_kontrol();

        // fence.i during BEKLE: refill answers first, then a full walk.
        gecikme = 6;
        k0 = kabul_sayisi;
        fork
            fetch(32'h0000_1804);
            begin
                kabul_bekle(k0);
                @(posedge clk); #1;
                temizle = 1'b1;
                @(posedge clk); #1;
                temizle = 1'b0;
            end
        join
        bekle_temizlik(-1);
        fetch(32'h0000_1804);

        // fence.i and a hit in the same idle cycle: no response, walk starts.
        fetch(32'h0000_1804);
        @(posedge clk); #1;
        ist_gecerli = 1'b1;
        ist_adres = 32'h0000_1804;
        temizle = 1'b1;
        @(negedge clk);
        check("temizle_oncelik_yanit_yok", yan_gecerli, 0);
        @(posedge clk); #1;
        ist_gecerli = 1'b0;
        bekle_temizlik(-1);
        sayac_kontrol();

        // Reset in the middle of a refill; the late data must be ignored and
        // the walk is restarted once by temizle.
        gecikme = 8;
        k0 = kabul_sayisi;
        exp_bel_q.push_back(32'h0000_2008);
        @(posedge clk); #1;
        ist_gecerli = 1'b1;
        ist_adres = 32'h0000_2008;
        kabul_bekle(k0);
        @(posedge clk); #1;
        reset_uygula();
        bekle_temizlik(100);
        fetch(32'h0000_2008);
        fetch(32'h0000_2008);
        sayac_kontrol();

        // Randomized traffic over a few rows and tags with random handshakes.
        rastgele = 1'b1;
        for (int i = 0; i < 80; i++) begin
            rast_adr = {($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'd0,
                        8'($urandom_range(0, 3)), 9'($urandom_range(0, 7)), 2'b00};
            fetch(rast_adr);
            if ($urandom_range(0, 15) == 0) temizle_darbe();
        end
        rastgele = 1'b0;
        repeat (10) @(negedge clk);
        sayac_kontrol();
        check("yanit_kuyrugu_bos", exp_q.size(), 0);
        check("istek_kuyrugu_bos", exp_bel_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", hata_sayisi, kontrol_sayisi);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
